bcd_divider: RTL and testbench
==============================

Name: bcd_divider

Overview:
Sequential 4-digit packed-BCD integer divider. It accepts a dividend and divisor on a start pulse, runs restoring long division one decimal digit at a time, and returns the BCD quotient and remainder with a done flag. It is a multi-cycle arithmetic unit for datapaths that keep values in packed BCD.

Parameters:
DIGITS, 4, number of BCD digits per operand/result (port widths = 4*DIGITS); only 4 is required to be supported

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  16  packed BCD, digit 3 in [15:12]
divisor  input  16  packed BCD
quotient  output  16  packed BCD quotient, registered
remainder  output  16  packed BCD remainder, registered
end_division  output  1  high while result valid (DONE state)

Behaviour:
- Reset (rst=0, async): state IDLE; quotient=0, remainder=0, end_division=0; operand and working registers cleared. Reset mid-operation aborts the division with no residual effect.
- States: IDLE, CHECK, SHIFT, SUB, DONE.
- IDLE: on start=1, latch dividend/divisor, clear quotient/remainder/working regs, go CHECK.
- CHECK: if divisor==0 or any nibble of either operand >9, load quotient=16'h9999, remainder=latched dividend (raw), go DONE (error result). Otherwise set digit index=3, partial remainder R (20-bit, 5 BCD digits)=0, go SHIFT.
- SHIFT: R <= {R[15:0], dividend digit[index]}; current quotient digit=0; go SUB.
- SUB: if R >= divisor (plain binary compare, valid for packed BCD): R <= R - divisor (BCD subtraction with per-digit borrow correction), quotient digit +1, stay SUB. Else store quotient digit at [index]; if index==0 go DONE with remainder=R[15:0], else index-1, go SHIFT.
- DONE: end_division=1; quotient/remainder held. On start=1: relatch operands, clear outputs, drop end_division, go CHECK (same as IDLE acceptance).
- start while in CHECK/SHIFT/SUB is ignored.
- Latency: start sampled at edge 0; end_division rises after edge L = 1 + sum over 4 digits of (2 + q_i), q_i = quotient digit. Error case L=2. Max L=45 (9999/1).
- quotient and remainder are valid only while end_division=1; they read 0 from start acceptance until DONE.
- Invariants on valid operands: dividend = quotient*divisor + remainder, remainder < divisor, all result nibbles <=9.

Decomposition:
- Shared package bcd_div_pkg: state enum (IDLE, CHECK, SHIFT, SUB, DONE), DIGITS constant, error quotient constant 16'h9999.
- One sub-module: bcd_subtractor (combinational, 5-digit minuend minus 4-digit subtrahend zero-extended, per-digit borrow/correct-by-10), instantiated once in SUB datapath.

Test Plan:
- Reset, start with dividend=16'h0025, divisor=16'h0004 -> quotient=16'h0006, remainder=16'h0001, end_division high 15 cycles after start edge.
- Start with 16'h0030 / 16'h0000 -> quotient=16'h9999, remainder=16'h0030, end_division after 2 cycles.
- Start with 16'h1234 / 16'h0012 -> quotient=16'h0102, remainder=16'h0010, latency 12.
- 16'h9999 / 16'h0001 -> quotient=16'h9999, remainder=0, latency 45; then 16'h0000 / 16'h0007 -> 0, 0.
- Invalid nibble 16'h00A1 / 16'h0003 -> error result (9999, 00A1); start pulsed mid-division of another operation ignored (result unchanged).
- Assert rst low mid-division of 1234/12 -> outputs 0, end_division 0 immediately; subsequent 25/4 completes correctly.

Source files
------------

// File: rtl/bcd_div_pkg.sv
// Shared definitions for the packed-BCD long divider.
package bcd_div_pkg;

   // Default operand width in BCD digits.
   localparam int NUM_DIGITS = 4;

   // Quotient reported when the operands cannot be divided.
   localparam logic [15:0] ERR_QUOTIENT = 16'h9999;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SHIFT,
      SUB,
      DONE
   } state_e;

endpackage

// File: rtl/bcd_subtractor.sv
// Combinational packed-BCD subtractor.
// The minuend is one digit wider than the subtrahend; the subtrahend is zero-extended.
module bcd_subtractor
   import bcd_div_pkg::*;
#(
   parameter int DIGITS = NUM_DIGITS
) (
   input  logic [4*DIGITS+3:0] minuend_i,
   input  logic [4*DIGITS-1:0] subtrahend_i,
   output logic [4*DIGITS+3:0] diff_o
);

   logic [4*DIGITS+3:0] sub_ext;

   assign sub_ext = {4'h0, subtrahend_i};

   // Ripple digit by digit; a negative digit result borrows from the next digit and is corrected by +10.
   always_comb begin
      logic       borrow;
      logic [4:0] t;
      diff_o = '0;
      borrow = 1'b0;
      t      = '0;
      for (int i = 0; i <= DIGITS; i++) begin
         t = {1'b0, minuend_i[4*i +: 4]} - {1'b0, sub_ext[4*i +: 4]} - {4'b0000, borrow};
         if (t[4]) begin
            diff_o[4*i +: 4] = t[3:0] + 4'd10;
            borrow           = 1'b1;
         end else begin
            diff_o[4*i +: 4] = t[3:0];
            borrow           = 1'b0;
         end
      end
   end

endmodule

// File: rtl/bcd_divider.sv
// Sequential packed-BCD restoring divider: one quotient digit per SHIFT/SUB pass,
// most significant digit first. Invalid operands or a zero divisor give quotient
// 9999 and the raw dividend as remainder.
module bcd_divider
   import bcd_div_pkg::*;
#(
   parameter int DIGITS = NUM_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] dividend,
   input  logic [4*DIGITS-1:0] divisor,
   output logic [4*DIGITS-1:0] quotient,
   output logic [4*DIGITS-1:0] remainder,
   output logic                end_division
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = $clog2(DIGITS);

   state_e          state_q, state_d;
   logic [W-1:0]    dvd_q, dvd_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    wq_q, wq_d;
   logic [W+3:0]    r_q, r_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [3:0]      qd_q, qd_d;
   logic            err_q, err_d;
   logic [W+3:0]    r_sub;

   // True when any nibble of the operand is not a decimal digit.
   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   bcd_subtractor #(.DIGITS(DIGITS)) u_sub (
      .minuend_i    (r_q),
      .subtrahend_i (dvs_q),
      .diff_o       (r_sub)
   );

   // State and datapath registers; reset also aborts any division in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         wq_q    <= '0;
         r_q     <= '0;
         idx_q   <= '0;
         qd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         wq_q    <= wq_d;
         r_q     <= r_d;
         idx_q   <= idx_d;
         qd_q    <= qd_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath control for the long-division sequence.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      wq_d    = wq_q;
      r_d     = r_q;
      idx_d   = idx_q;
      qd_d    = qd_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               quo_d   = '0;
               rem_d   = '0;
               wq_d    = '0;
               r_d     = '0;
               idx_d   = '0;
               qd_d    = '0;
               err_d   = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // The error path spends a second cycle here so its latency is a fixed two cycles
            // and the outputs stay zero until DONE.
            if (err_q) begin
               quo_d   = ERR_QUOTIENT;
               rem_d   = dvd_q;
               err_d   = 1'b0;
               state_d = DONE;
            end else if (dvs_q == '0 || has_bad_digit(dvd_q) || has_bad_digit(dvs_q)) begin
               err_d   = 1'b1;
            end else begin
               idx_d   = IW'(DIGITS - 1);
               r_d     = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            r_d     = {r_q[W-1:0], dvd_q[4*idx_q +: 4]};
            qd_d    = '0;
            state_d = SUB;
         end
         SUB: begin
            // Packed BCD orders the same as binary, so a plain compare decides the subtraction.
            if (r_q >= {4'h0, dvs_q}) begin
               r_d  = r_sub;
               qd_d = qd_q + 4'd1;
            end else begin
               wq_d[4*idx_q +: 4] = qd_q;
               if (idx_q == '0) begin
                  quo_d   = wq_d;
                  rem_d   = r_q[W-1:0];
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SHIFT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign quotient     = quo_q;
   assign remainder    = rem_q;
   assign end_division = (state_q == DONE);

endmodule

// File: tb/tb_bcd_divider.sv
// Directed testbench for bcd_divider: results, latencies, error cases, ignored starts and async reset.
module tb_bcd_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        end_division;

   int n_assert = 0;
   int n_fail   = 0;
   int lat;

   bcd_divider #(.DIGITS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dividend     (dividend),
      .divisor      (divisor),
      .quotient     (quotient),
      .remainder    (remainder),
      .end_division (end_division)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands with start for exactly one rising edge (edge 0), then confirm acceptance.
   task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_acc_end"}, {31'b0, end_division}, 32'd0);
      check({tag, "_acc_q"}, {16'b0, quotient}, 32'd0);
      check({tag, "_acc_r"}, {16'b0, remainder}, 32'd0);
   endtask

   // Count edges until end_division is seen, bounded so a stuck DUT still reaches the summary.
   task automatic wait_done(output int n);
      n = 0;
      while (!end_division && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic [15:0] r, input int exp_lat);
      int n;
      start_op(tag, a, b);
      wait_done(n);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_q"}, {16'b0, quotient}, {16'b0, q});
      check({tag, "_r"}, {16'b0, remainder}, {16'b0, r});
      check({tag, "_end"}, {31'b0, end_division}, 32'd1);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_q", {16'b0, quotient}, 32'd0);
      check("rst_r", {16'b0, remainder}, 32'd0);
      check("rst_end", {31'b0, end_division}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_end", {31'b0, end_division}, 32'd0);

      // Main function and boundaries
      run("d25_4", 16'h0025, 16'h0004, 16'h0006, 16'h0001, 15);
      run("d30_0", 16'h0030, 16'h0000, 16'h9999, 16'h0030, 2);
      run("d1234_12", 16'h1234, 16'h0012, 16'h0102, 16'h0010, 12);
      run("d9999_1", 16'h9999, 16'h0001, 16'h9999, 16'h0000, 45);

      // Result holds in DONE without start
      repeat (3) @(posedge clk);
      #1;
      check("hold_q", {16'b0, quotient}, 32'h9999);
      check("hold_end", {31'b0, end_division}, 32'd1);

      // Async reset while a result is displayed
      rst = 1'b0;
      #1;
      check("rstdone_q", {16'b0, quotient}, 32'd0);
      check("rstdone_end", {31'b0, end_division}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run("d0_7", 16'h0000, 16'h0007, 16'h0000, 16'h0000, 9);
      run("dA1_3", 16'h00A1, 16'h0003, 16'h9999, 16'h00A1, 2);

      // start held high during CHECK/SHIFT/SUB with other operands must be ignored
      start_op("d100_3", 16'h0100, 16'h0003);
      dividend = 16'h9999;
      divisor  = 16'h0001;
      start    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      check("ign_end", {31'b0, end_division}, 32'd0);
      check("ign_q", {16'b0, quotient}, 32'd0);
      wait_done(lat);
      check("ign_lat", lat, 32'd12);
      check("ign_qf", {16'b0, quotient}, 32'h0033);
      check("ign_rf", {16'b0, remainder}, 32'h0001);

      // Async reset in the middle of a division
      start_op("abort", 16'h1234, 16'h0012);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_q", {16'b0, quotient}, 32'd0);
      check("abort_r", {16'b0, remainder}, 32'd0);
      check("abort_end", {31'b0, end_division}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_idle_end", {31'b0, end_division}, 32'd0);

      run("post_25_4", 16'h0025, 16'h0004, 16'h0006, 16'h0001, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
